// File: rtl/rate_pacer.sv
// Programmable-rate beat generator: one-cycle pulse plus a 50% phase_on level at BASE_HZ*2^speed,
// with pause/resume, free-run or one-shot (N beats), beat index and done/busy status.
module rate_pacer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BASE_HZ    = 1,
  parameter int NUM_SPEEDS = 5,
  parameter int SPEED_W    = 3,
  parameter int BEAT_W     = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_speed,
  input  logic [SPEED_W-1:0] speed,
  input  logic               enable,
  input  logic               oneshot,
  input  logic [BEAT_W-1:0]  beats,
  output logic               pulse,
  output logic               phase_on,
  output logic [BEAT_W-1:0]  beat_idx,
  output logic               busy,
  output logic               done
);

  localparam int BASE_P    = CLK_HZ / BASE_HZ;
  localparam int CNT_W     = $clog2(BASE_P);
  localparam int NUM_SLOTS = 2 ** SPEED_W;
  localparam logic [SPEED_W-1:0] MAX_SPEED = SPEED_W'(NUM_SPEEDS - 1);

  generate
    if ((BASE_P >> (NUM_SPEEDS - 1)) < 2) begin : g_bad_params
      $error("rate_pacer: fastest period BASE_P >> (NUM_SPEEDS-1) must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   counter_reg;
  logic [SPEED_W-1:0] speed_q_reg;
  logic               oneshot_reg;
  logic [BEAT_W-1:0]  beats_reg;
  logic [BEAT_W-1:0]  beat_idx_reg;

  // Reload (P-1) and half-period (P/2) per speed code; out-of-range codes map to the fastest rate.
  logic [CNT_W-1:0] reload_tab [NUM_SLOTS];
  logic [CNT_W-1:0] half_tab   [NUM_SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_period
      localparam int S_EFF = (gi < NUM_SPEEDS) ? gi : NUM_SPEEDS - 1;
      assign reload_tab[gi] = CNT_W'((BASE_P >> S_EFF) - 1);
      assign half_tab[gi]   = CNT_W'((BASE_P >> S_EFF) / 2);
    end
  endgenerate

  logic [SPEED_W-1:0] s_eff;
  logic [CNT_W-1:0]   cur_reload;
  logic [CNT_W-1:0]   cur_half;
  logic [BEAT_W-1:0]  beat_next;
  logic               at_zero;
  logic               last_beat;

  assign s_eff      = (speed > MAX_SPEED) ? MAX_SPEED : speed;
  assign cur_reload = reload_tab[speed_q_reg];
  assign cur_half   = half_tab[speed_q_reg];
  assign beat_next  = beat_idx_reg + BEAT_W'(1);
  assign at_zero    = (counter_reg == '0);
  assign last_beat  = oneshot_reg && (beat_next == beats_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      counter_reg  <= '0;
      speed_q_reg  <= '0;
      oneshot_reg  <= 1'b0;
      beats_reg    <= '0;
      beat_idx_reg <= '0;
    end else if (load_speed) begin
      speed_q_reg  <= s_eff;
      counter_reg  <= reload_tab[s_eff];
      beat_idx_reg <= '0;
      oneshot_reg  <= oneshot;
      beats_reg    <= beats;
      if (oneshot && (beats == '0)) begin
        state_reg <= DONE;
      end else if (enable) begin
        state_reg <= RUN;
      end else begin
        state_reg <= PAUSE;
      end
    end else begin
      case (state_reg)
        RUN: begin
          // A pulse on the same cycle enable drops still completes its reload.
          if (at_zero) begin
            counter_reg  <= cur_reload;
            beat_idx_reg <= beat_next;
          end else begin
            counter_reg <= counter_reg - CNT_W'(1);
          end
          if (at_zero && last_beat) begin
            state_reg <= DONE;
          end else if (!enable) begin
            state_reg <= PAUSE;
          end
        end
        PAUSE: begin
          if (enable) begin
            state_reg <= RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // All outputs decode registered state only, so they clear the instant reset asserts.
  assign busy     = (state_reg == RUN) || (state_reg == PAUSE);
  assign done     = (state_reg == DONE);
  assign pulse    = (state_reg == RUN) && at_zero;
  assign phase_on = busy && (counter_reg >= cur_half);
  assign beat_idx = beat_idx_reg;

endmodule

// File: tb/tb_rate_pacer.sv
// Directed bench for rate_pacer at CLK_HZ=64, BASE_HZ=1, NUM_SPEEDS=5 (periods 64,32,16,8,4).
module tb_rate_pacer;

  logic       clk;
  logic       reset_n;
  logic       load_speed;
  logic [2:0] speed;
  logic       enable;
  logic       oneshot;
  logic [5:0] beats;
  logic       pulse;
  logic       phase_on;
  logic [5:0] beat_idx;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  rate_pacer #(
    .CLK_HZ     (64),
    .BASE_HZ    (1),
    .NUM_SPEEDS (5),
    .SPEED_W    (3),
    .BEAT_W     (6)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_speed (load_speed),
    .speed      (speed),
    .enable     (enable),
    .oneshot    (oneshot),
    .beats      (beats),
    .pulse      (pulse),
    .phase_on   (phase_on),
    .beat_idx   (beat_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pulse();
    load_speed = 1'b1;
    tick();
    load_speed = 1'b0;
  endtask

  initial begin
    reset_n    = 1'b0;
    load_speed = 1'b0;
    speed      = 3'd0;
    enable     = 1'b0;
    oneshot    = 1'b0;
    beats      = 6'd0;

    #2;
    chk("rst_pulse", pulse, 0);
    chk("rst_phase", phase_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", beat_idx, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_pulse", pulse, 0);

    // 1: speed 2 free-run, period 16; later speed/oneshot/beats changes are ignored
    speed = 3'd2; enable = 1'b1; oneshot = 1'b0;
    load_pulse();
    speed = 3'd0; oneshot = 1'b1; beats = 6'd1;
    for (int c = 1; c <= 48; c++) begin
      chk("t1_pulse", pulse, (c % 16) == 0);
      chk("t1_phase", phase_on, ((c - 1) % 16) < 8);
      chk("t1_idx", beat_idx, (c - 1) / 16);
      chk("t1_busy", busy, 1);
      tick();
    end

    // 2: speed 7 clamps to 4, period 4
    speed = 3'd7; oneshot = 1'b0;
    load_pulse();
    for (int c = 1; c <= 12; c++) begin
      chk("t2_pulse", pulse, (c % 4) == 0);
      chk("t2_phase", phase_on, ((c - 1) % 4) < 2);
      chk("t2_idx", beat_idx, (c - 1) / 4);
      tick();
    end

    // 3: one-shot, speed 3 (period 8), three beats
    speed = 3'd3; oneshot = 1'b1; beats = 6'd3;
    load_pulse();
    for (int c = 1; c <= 30; c++) begin
      chk("t3_pulse", pulse, (c == 8) || (c == 16) || (c == 24));
      chk("t3_done", done, c >= 25);
      chk("t3_busy", busy, c < 25);
      chk("t3_phase", phase_on, (c < 25) && (((c - 1) % 8) < 4));
      chk("t3_idx", beat_idx, (c < 25) ? (c - 1) / 8 : 3);
      tick();
    end
    beats = 6'd0;
    load_pulse();
    for (int c = 1; c <= 5; c++) begin
      chk("t3z_done", done, 1);
      chk("t3z_busy", busy, 0);
      chk("t3z_pulse", pulse, 0);
      chk("t3z_idx", beat_idx, 0);
      tick();
    end

    // 4: speed 2 run, enable low during cycles 5..14 pushes the first pulse to 26
    speed = 3'd2; oneshot = 1'b0; enable = 1'b1;
    load_pulse();
    for (int c = 1; c <= 28; c++) begin
      chk("t4_pulse", pulse, c == 26);
      chk("t4_phase", phase_on, (c <= 18) || (c >= 27));
      chk("t4_idx", beat_idx, c >= 27);
      chk("t4_busy", busy, 1);
      enable = !((c >= 5) && (c <= 14));
      tick();
    end
    enable = 1'b1;

    // 5: speed 0 run reloaded to speed 1 at cycle 20, next pulse at 52
    speed = 3'd0;
    load_pulse();
    for (int c = 1; c <= 56; c++) begin
      chk("t5_pulse", pulse, c == 52);
      chk("t5_phase", phase_on, (c <= 36) || (c >= 53));
      chk("t5_idx", beat_idx, c >= 53);
      if (c == 20) begin
        speed = 3'd1;
        load_speed = 1'b1;
      end else begin
        load_speed = 1'b0;
      end
      tick();
    end

    // 6: asynchronous reset between clock edges
    speed = 3'd2;
    load_pulse();
    repeat (20) tick();
    chk("t6_pre_busy", busy, 1);
    chk("t6_pre_phase", phase_on, 1);
    chk("t6_pre_idx", beat_idx, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_phase", phase_on, 0);
    chk("t6_rst_idx", beat_idx, 0);
    chk("t6_rst_pulse", pulse, 0);
    chk("t6_rst_done", done, 0);
    #2;
    reset_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("t6_idle_busy", busy, 0);
      chk("t6_idle_phase", phase_on, 0);
      chk("t6_idle_pulse", pulse, 0);
      chk("t6_idle_idx", beat_idx, 0);
      chk("t6_idle_done", done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
